// File: rtl/cpu_types_pkg.sv
// Core-wide scalar types shared by the fetch and execute datapaths.
// Types only: no logic, no latency, no flow control.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/datapath_types_pkg.sv
// Branch-prediction types: 2-bit direction counter encoding and the BTB entry layout.
// Types only: no logic, no latency, no flow control.
package datapath_types_pkg;

    import cpu_types_pkg::*;

    // Widest tag the BTB can need (IDX_W >= 0, two byte-offset bits dropped).
    localparam int BTB_TAG_MAX_W = WORD_W - 2;

    typedef logic [BTB_TAG_MAX_W-1:0] btb_tag_t;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } bp_ctr_t;

    typedef struct packed {
        logic     valid;
        btb_tag_t tag;
        word_t    target;
        bp_ctr_t  ctr;
    } btb_entry_t;

endpackage

// File: rtl/sat_ctr2.sv
// 2-bit saturating direction counter next-state: one step toward the resolved outcome.
// Latency: purely combinational; no backpressure.
module sat_ctr2
    import datapath_types_pkg::*;
(
    input  bp_ctr_t cur,
    input  logic    taken,
    output bp_ctr_t nxt
);

    logic [1:0] cur_v;

    assign cur_v = cur;

    always_comb begin
        nxt = cur;
        if (taken) begin
            if (cur != STRONG_T) begin
                nxt = bp_ctr_t'(cur_v + 2'd1);
            end
        end else begin
            if (cur != STRONG_NT) begin
                nxt = bp_ctr_t'(cur_v - 2'd1);
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, trained by resolved branches, plus stats.
// Latency: lookup 0 cycles (combinational), update visible next cycle; no backpressure.
module branch_predictor
    import cpu_types_pkg::*;
    import datapath_types_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic  CLK,
    input  logic  nRST,
    input  word_t iaddr,
    output logic  pred_control,
    output word_t pred_branch,
    input  logic  upd_en,
    input  word_t upd_pc,
    input  logic  upd_taken,
    input  word_t upd_target,
    input  logic  upd_pred,
    output logic  mispredict,
    output word_t branch_cnt,
    output word_t mispred_cnt
);

    localparam int TAG_W   = WORD_W - IDX_W - 2;
    localparam int ENTRIES = 1 << IDX_W;

    btb_entry_t btb_q [ENTRIES];

    logic       mispredict_q, mispredict_d;
    word_t      branch_cnt_q, branch_cnt_d;
    word_t      mispred_cnt_q, mispred_cnt_d;

    logic [IDX_W-1:0] lk_idx, up_idx;
    btb_tag_t   lk_tag, up_tag;
    btb_entry_t lk_ent, up_ent, up_ent_d;
    logic       lk_hit, up_hit, up_wr;
    bp_ctr_t    ctr_nxt;
    logic       is_mispred;

    // Byte-offset bits never participate: unaligned addresses alias their word.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{iaddr[1:0], upd_pc[1:0]};

    // Lookup reads registered state only, so a same-cycle update is not bypassed.
    assign lk_idx = iaddr[IDX_W+1:2];
    assign lk_tag = btb_tag_t'(iaddr[WORD_W-1:IDX_W+2]);
    assign lk_ent = btb_q[lk_idx];
    assign lk_hit = lk_ent.valid && (lk_ent.tag == lk_tag);

    assign pred_control = lk_hit & lk_ent.ctr[1];
    assign pred_branch  = lk_hit ? lk_ent.target : '0;

    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = btb_tag_t'(upd_pc[WORD_W-1:IDX_W+2]);
    assign up_ent = btb_q[up_idx];
    assign up_hit = up_ent.valid && (up_ent.tag == up_tag);

    sat_ctr2 u_sat_ctr2 (
        .cur   (up_ent.ctr),
        .taken (upd_taken),
        .nxt   (ctr_nxt)
    );

    always_comb begin
        up_ent_d = up_ent;
        up_wr    = 1'b0;
        if (upd_en) begin
            if (up_hit) begin
                up_wr        = 1'b1;
                up_ent_d.ctr = ctr_nxt;
                if (upd_taken) begin
                    up_ent_d.target = upd_target;
                end
            end else if (upd_taken) begin
                // Taken miss evicts whatever occupies the slot.
                up_wr           = 1'b1;
                up_ent_d.valid  = 1'b1;
                up_ent_d.tag    = up_tag;
                up_ent_d.target = upd_target;
                up_ent_d.ctr    = WEAK_T;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WEAK_NT};
            end
        end else if (up_wr) begin
            btb_q[up_idx] <= up_ent_d;
        end
    end

    assign is_mispred = upd_pred ^ upd_taken;

    always_comb begin
        mispredict_d  = upd_en & is_mispred;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (upd_en && (branch_cnt_q != '1)) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
        end
        if (upd_en && is_mispred && (mispred_cnt_q != '1)) begin
            mispred_cnt_d = mispred_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mispredict_q  <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            mispredict_q  <= mispredict_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign mispredict  = mispredict_q;
    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with a table-level reference model and per-cycle compare.
module tb_branch_predictor;

    logic        CLK;
    logic        nRST;
    logic [31:0] iaddr;
    logic        pred_control;
    logic [31:0] pred_branch;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred;
    logic        mispredict;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    branch_predictor #(.IDX_W(4)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .iaddr        (iaddr),
        .pred_control (pred_control),
        .pred_branch  (pred_branch),
        .upd_en       (upd_en),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .upd_target   (upd_target),
        .upd_pred     (upd_pred),
        .mispredict   (mispredict),
        .branch_cnt   (branch_cnt),
        .mispred_cnt  (mispred_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: one slot per word-address index, counter held as an integer 0..3.
    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    logic [31:0] m_bcnt;
    logic [31:0] m_mcnt;
    bit          m_misp;

    function automatic int midx(input logic [31:0] a);
        return int'(a[5:2]);
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < 16; i++) begin
                m_valid[i] = 0;
                m_tag[i]   = 0;
                m_tgt[i]   = 0;
                m_ctr[i]   = 1;
            end
            m_bcnt = 0;
            m_mcnt = 0;
            m_misp = 0;
        end else begin
            m_misp = upd_en && (upd_pred != upd_taken);
            if (upd_en) begin
                int  i;
                bit  hit;
                if (m_bcnt != 32'hFFFF_FFFF) m_bcnt = m_bcnt + 1;
                if (m_misp && m_mcnt != 32'hFFFF_FFFF) m_mcnt = m_mcnt + 1;
                i   = midx(upd_pc);
                hit = m_valid[i] && (m_tag[i] == (upd_pc >> 6));
                if (hit) begin
                    if (upd_taken) begin
                        m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                        m_tgt[i] = upd_target;
                    end else begin
                        m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                    end
                end else if (upd_taken) begin
                    m_valid[i] = 1;
                    m_tag[i]   = upd_pc >> 6;
                    m_tgt[i]   = upd_target;
                    m_ctr[i]   = 2;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            int  i;
            bit  hit;
            i   = midx(iaddr);
            hit = m_valid[i] && (m_tag[i] == (iaddr >> 6));
            chk1("cmp_pred_control", pred_control, hit && (m_ctr[i] >= 2));
            chk("cmp_pred_branch", pred_branch, hit ? m_tgt[i] : 32'h0);
            chk1("cmp_mispredict", mispredict, m_misp);
            chk("cmp_branch_cnt", branch_cnt, m_bcnt);
            chk("cmp_mispred_cnt", mispred_cnt, m_mcnt);
        end
    end

    task automatic apply(input bit en, input logic [31:0] pc, input bit tk,
                         input logic [31:0] tg, input bit pr);
        upd_en     = en;
        upd_pc     = pc;
        upd_taken  = tk;
        upd_target = tg;
        upd_pred   = pr;
    endtask

    task automatic edge_step();
        @(posedge CLK);
        #1;
        upd_en = 1'b0;
    endtask

    task automatic tick(input bit en, input logic [31:0] pc, input bit tk,
                        input logic [31:0] tg, input bit pr);
        apply(en, pc, tk, tg, pr);
        edge_step();
    endtask

    initial begin
        nRST  = 1'b1;
        iaddr = 32'h0000_0040;
        apply(0, 32'h0, 0, 32'h0, 0);
        #2 nRST = 1'b0;
        #1;
        chk1("reset_pred_control", pred_control, 1'b0);
        chk("reset_pred_branch", pred_branch, 32'h0);
        chk("reset_branch_cnt", branch_cnt, 32'h0);
        chk("reset_mispred_cnt", mispred_cnt, 32'h0);
        chk1("reset_mispredict", mispredict, 1'b0);
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
        chk_en = 1;

        // Allocation of 0x40 while looking it up in the same cycle.
        apply(1, 32'h40, 1, 32'h100, 0);
        #1 chk1("hazard_same_cycle", pred_control, 1'b0);
        edge_step();
        chk1("alloc_pred_control", pred_control, 1'b1);
        chk("alloc_pred_branch", pred_branch, 32'h100);
        chk1("alloc_mispredict", mispredict, 1'b1);
        chk("alloc_branch_cnt", branch_cnt, 32'd1);
        chk("alloc_mispred_cnt", mispred_cnt, 32'd1);

        tick(1, 32'h40, 1, 32'h100, 1);
        tick(1, 32'h40, 1, 32'h200, 1);
        chk("taken_target_update", pred_branch, 32'h200);
        chk1("taken_no_mispredict", mispredict, 1'b0);
        chk("taken_branch_cnt", branch_cnt, 32'd3);

        tick(1, 32'h40, 0, 32'hDEAD_0000, 1);
        chk1("nt1_pred_control", pred_control, 1'b1);
        chk("nt1_target_kept", pred_branch, 32'h200);
        tick(1, 32'h40, 0, 32'hDEAD_0000, 1);
        chk1("nt2_pred_control", pred_control, 1'b0);
        tick(1, 32'h40, 0, 32'hDEAD_0000, 1);
        tick(1, 32'h40, 1, 32'h200, 0);
        chk1("sat_00_then_taken", pred_control, 1'b0);
        tick(1, 32'h40, 1, 32'h200, 0);
        chk1("back_to_weak_t", pred_control, 1'b1);
        chk("train_branch_cnt", branch_cnt, 32'd8);
        chk("train_mispred_cnt", mispred_cnt, 32'd6);

        // Not-taken miss leaves the BTB untouched.
        iaddr = 32'h80;
        tick(1, 32'h80, 0, 32'h400, 0);
        chk1("nt_miss_pred_control", pred_control, 1'b0);
        chk("nt_miss_pred_branch", pred_branch, 32'h0);
        chk("nt_miss_branch_cnt", branch_cnt, 32'd9);

        // 0x80 shares index 0 with 0x40 and evicts it.
        tick(1, 32'h80, 1, 32'h300, 0);
        chk1("alias_new_hit", pred_control, 1'b1);
        chk("alias_new_target", pred_branch, 32'h300);
        iaddr = 32'h40;
        #1 chk1("alias_old_miss", pred_control, 1'b0);
        chk("alias_old_branch", pred_branch, 32'h0);
        iaddr = 32'h83;
        #1 chk("unaligned_lookup", pred_branch, 32'h300);

        tick(0, 32'h0, 0, 32'h0, 0);
        chk1("idle_mispredict_clear", mispredict, 1'b0);
        chk("idle_branch_cnt", branch_cnt, 32'd10);
        chk("idle_mispred_cnt", mispred_cnt, 32'd7);

        // Preload both statistics counters at their ceiling.
        force dut.branch_cnt_q  = 32'hFFFF_FFFF;
        force dut.mispred_cnt_q = 32'hFFFF_FFFF;
        m_bcnt = 32'hFFFF_FFFF;
        m_mcnt = 32'hFFFF_FFFF;
        #1;
        release dut.branch_cnt_q;
        release dut.mispred_cnt_q;
        iaddr = 32'h40;
        tick(1, 32'h40, 1, 32'h500, 0);
        chk("sat_branch_cnt", branch_cnt, 32'hFFFF_FFFF);
        chk("sat_mispred_cnt", mispred_cnt, 32'hFFFF_FFFF);
        chk1("sat_realloc_hit", pred_control, 1'b1);

        // Reset between edges, with an allocating update pending across the edge.
        @(posedge CLK);
        #3 nRST = 1'b0;
        #1;
        chk("async_branch_cnt", branch_cnt, 32'h0);
        chk("async_mispred_cnt", mispred_cnt, 32'h0);
        chk1("async_pred_control", pred_control, 1'b0);
        chk("async_pred_branch", pred_branch, 32'h0);
        iaddr = 32'hC0;
        apply(1, 32'hC0, 1, 32'h700, 1);
        edge_step();
        chk1("reset_discards_write", pred_control, 1'b0);
        chk("reset_discards_cnt", branch_cnt, 32'h0);
        nRST = 1'b1;
        tick(0, 32'h0, 0, 32'h0, 0);
        tick(1, 32'hC0, 1, 32'h700, 1);
        chk1("post_reset_alloc", pred_control, 1'b1);
        chk("post_reset_target", pred_branch, 32'h700);
        tick(0, 32'h0, 0, 32'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters.
- Sits upstream of the PC stage: it looks up the current fetch address and drives pred_control/pred_branch into the PC's next-address logic.
- Trained by resolved branch outcomes from the execute/memory stage.
- Keeps branch and mispredict statistics counters for performance measurement.

Parameters:
IDX_W, 4, index width; entries = 2**IDX_W, indexed by address bits [IDX_W+1:2]
TAG_W, 32-IDX_W-2, tag width; tag = address bits [31:IDX_W+2] (derived, not overridden)

Ports:
CLK  input  1  system clock, rising-edge
nRST  input  1  asynchronous active-low reset
iaddr  input  32  current fetch address from PC
pred_control  output  1  predict taken for iaddr (combinational)
pred_branch  output  32  predicted target for iaddr (combinational)
upd_en  input  1  a branch resolved this cycle
upd_pc  input  32  address of the resolved branch
upd_taken  input  1  actual direction
upd_target  input  32  actual taken target
upd_pred  input  1  prediction originally made for this branch
mispredict  output  1  registered; upd_pred != upd_taken on the last update
branch_cnt  output  32  resolved-branch count, saturating
mispred_cnt  output  32  mispredict count, saturating

Behaviour:
- Reset (async, nRST=0):
  - All valid bits 0; all counters WEAK_NT (01); tags/targets 0.
  - mispredict=0, branch_cnt=0, mispred_cnt=0.
  - Outputs take their reset values immediately, without waiting for a clock edge.
- Lookup (0-cycle latency, pure combinational):
  - hit = valid[idx] & (tag[idx] == iaddr tag).
  - pred_control = hit & ctr[idx][1].
  - pred_branch = target[idx] on a hit, otherwise 0.
- Update (takes effect at the rising edge when upd_en=1):
  - Tag hit: counter moves one step toward upd_taken, saturating (00 stays 00 on not-taken, 11 stays 11 on taken). If upd_taken=1, the target is overwritten with upd_target.
  - Miss with upd_taken=1: allocate the entry, overwriting any occupant. valid=1, tag and target written, counter = WEAK_T (10).
  - Miss with upd_taken=0: BTB unchanged.
- Statistics, every cycle with upd_en=1:
  - branch_cnt increments, holding at 32'hFFFF_FFFF.
  - mispred_cnt increments when upd_pred != upd_taken, also saturating.
  - mispredict register <= (upd_pred != upd_taken).
  - When upd_en=0, mispredict <= 0.
- Simultaneous lookup and update to the same index: the lookup returns pre-update state (no bypass). The new state is visible from the next cycle.
- Aliasing: two branches sharing an index with different tags evict each other. There is no replacement policy beyond overwrite.
- Upper bits of iaddr/upd_pc: the two LSBs are ignored. Unaligned addresses are treated as aligned.
- Reset asserted mid-update: reset wins and the pending write is discarded.

Decomposition:
- Shared datapath_types_pkg gets:
  - enum bp_ctr_t {STRONG_NT=2'b00, WEAK_NT=2'b01, WEAK_T=2'b10, STRONG_T=2'b11}
  - struct btb_entry_t {valid, tag, target word_t, ctr bp_ctr_t}
- word_t comes from cpu_types_pkg.
- Sub-module sat_ctr2: purely combinational next-state for the 2-bit counter (inputs cur, taken; output nxt). It is instantiated once, on the update path.

Test Plan:
- Reset, then iaddr=32'h0000_0040 -> pred_control=0, pred_branch=0, branch_cnt=0, mispred_cnt=0.
- Taken branch allocation and counter training, branch at 32'h0000_0040 with target 32'h0000_0100:
  - upd_en=1, upd_pc=32'h40, upd_taken=1, upd_target=32'h100, upd_pred=0 -> next cycle pred_control=1, pred_branch=32'h100, mispredict=1, branch_cnt=1, mispred_cnt=1.
  - Two more taken updates -> counter at 11.
  - Three not-taken updates -> pred_control=1 after the first, 0 after the second; the counter saturates at 00 after the third.
- Not-taken miss, upd_pc=32'h80, upd_taken=0 -> lookup of iaddr=32'h80 still misses (pred_control=0), branch_cnt increments.
- Aliasing with IDX_W=4:
  - Allocate 32'h0000_0040, then allocate 32'h0000_0080 (same index 0).
  - Lookup iaddr=32'h40 -> miss (pred_control=0); lookup iaddr=32'h80 -> hit.
- Same-cycle hazard: iaddr=32'h40 while the allocating update for 32'h40 is applied -> pred_control=0 that cycle, 1 the next.
- Saturation and async reset:
  - Force branch_cnt to 32'hFFFF_FFFF, apply upd_en -> stays FFFF_FFFF.
  - Assert nRST=0 between clock edges -> all counters and the BTB clear immediately.
